// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: control generator for a STAGES-deep in-order pipeline.
// Tracks which stages hold valid instructions, drives the per-stage IR load
// strobes, resolves conditional branches in EXEC with a squash of the
// younger stages, detects WB->EXEC operand hazards for forwarding, latches a
// sticky done when a stop retires, and counts run/stall cycles.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   N, Z                  ALU flags for the instruction in EXEC
//   mem_busy              memory not ready; freezes the pipeline this cycle
//   ir_bus[8*STAGES]      byte k = instruction register of stage k+1
//   ir_load[STAGES]       bit k loads the IR of stage k+1
//   en[STAGES]            bit k = stage k+1 holds a valid instruction
//   branch                taken branch in EXEC (flush request)
//   bypass_a, bypass_b    forward the WB result to ALU operand A / B
//   done                  a valid stop has retired (sticky until reset)
//   cycle_cnt, stall_cnt  saturating run / stall cycle counters
module pipe_ctrl_gen #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  N,
  input  logic                  Z,
  input  logic                  mem_busy,
  input  logic [8*STAGES-1:0]   ir_bus,
  output logic [STAGES-1:0]     ir_load,
  output logic [STAGES-1:0]     en,
  output logic                  branch,
  output logic                  bypass_a,
  output logic                  bypass_b,
  output logic                  done,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STOP  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_BZ    = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_NAND  = 4'd8;
  localparam logic [3:0] OP_BNZ   = 4'd9;
  localparam logic [3:0] OP_BPZ   = 4'd13;
  // These two decode on the low three bits only.
  localparam logic [2:0] OP_SHIFT = 3'd3;
  localparam logic [2:0] OP_ORI   = 3'd7;

  logic [7:0]        ir1, ir_ex, ir_wb;
  logic [STAGES-1:0] v;
  logic              adv, ir1_stop, taken, v0_next;
  logic              wb_ori, wb_alu, wb_wr;
  logic [1:0]        wb_reg;
  logic              ex_a_user, ex_b_user, ex_ori;
  logic              unused_ir;

  assign ir1   = ir_bus[7:0];
  assign ir_ex = ir_bus[8*(STAGES-2) +: 8];
  assign ir_wb = ir_bus[8*(STAGES-1) +: 8];

  // Middle-stage IRs and some operand fields are never decoded here.
  assign unused_ir = ^ir_bus;

  assign adv      = !mem_busy && !done;
  assign ir1_stop = (ir1[3:0] == OP_STOP);
  assign v0_next  = !ir1_stop || branch;

  // Stage 1 is always live until done; later stages follow the valid chain.
  always_comb begin
    en = '0;
    if (!done) en = {v[STAGES-1:1], 1'b1};
  end

  // A stop in IR1 stops fetching: IR1 holds while bubbles flow behind it.
  assign ir_load = {{(STAGES-1){adv}}, adv && v0_next};

  always_comb begin
    taken = 1'b0;
    case (ir_ex[3:0])
      OP_BPZ:  taken = !N;
      OP_BNZ:  taken = !Z;
      OP_BZ:   taken = Z;
      default: taken = 1'b0;
    endcase
  end

  // Gating with !mem_busy defers a taken branch until the stall clears.
  assign branch = en[STAGES-2] && !mem_busy && taken;

  assign wb_ori = (ir_wb[2:0] == OP_ORI);
  assign wb_alu = (ir_wb[2:0] == OP_SHIFT) || (ir_wb[3:0] == OP_ADD) ||
                  (ir_wb[3:0] == OP_SUB)   || (ir_wb[3:0] == OP_NAND);
  assign wb_wr  = en[STAGES-1] && (wb_ori || wb_alu);
  assign wb_reg = wb_ori ? 2'd1 : ir_wb[7:6];

  assign ex_ori    = (ir_ex[2:0] == OP_ORI);
  assign ex_a_user = (ir_ex[2:0] == OP_SHIFT) || (ir_ex[3:0] == OP_ADD) ||
                     (ir_ex[3:0] == OP_SUB)   || (ir_ex[3:0] == OP_NAND) ||
                     (ir_ex[3:0] == OP_LOAD);
  assign ex_b_user = (ir_ex[3:0] == OP_ADD)  || (ir_ex[3:0] == OP_SUB) ||
                     (ir_ex[3:0] == OP_NAND) || (ir_ex[3:0] == OP_LOAD) ||
                     (ir_ex[3:0] == OP_STORE);

  // ori reads r1 implicitly as its A operand.
  assign bypass_a = en[STAGES-2] && wb_wr &&
                    ((ex_a_user && (ir_ex[7:6] == wb_reg)) ||
                     (ex_ori && (wb_reg == 2'd1)));
  assign bypass_b = en[STAGES-2] && wb_wr && ex_b_user &&
                    (ir_ex[5:4] == wb_reg);

  // A branch squashes the younger stages; the branch itself moves on to WB.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v <= '0;
    end else if (adv) begin
      v[0] <= v0_next;
      for (int unsigned k = 1; k < STAGES - 1; k++) begin
        v[k] <= branch ? 1'b0 : v[k-1];
      end
      v[STAGES-1] <= branch || v[STAGES-2];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else if (en[STAGES-1] && (ir_wb[3:0] == OP_STOP)) begin
      done <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else if (!done) begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (mem_busy && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
